// File: rtl/jk_mod_counter_pkg.sv
// jk_mod_counter_pkg: JK command encoding and minimal-excitation helper shared by the counter.
package jk_mod_counter_pkg;
   typedef enum logic [1:0] {
      JK_HOLD = 2'b00,
      JK_CLR  = 2'b01,
      JK_SET  = 2'b10,
      JK_TOG  = 2'b11
   } jk_cmd_e;
   // {j,k} that moves one bit from q to n without ever using the toggle code
   function automatic jk_cmd_e jk_min(input logic q, input logic n);
      return jk_cmd_e'({~q & n, q & ~n});
   endfunction
endpackage

// File: rtl/jk_mod_counter_jk_cell.sv
// jk_cell: single-bit JK flip-flop (hold/set/clear/toggle), async active-low clear.
module jk_cell
   import jk_mod_counter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   output logic q
);
   jk_cmd_e w_cmd;
   assign w_cmd = jk_cmd_e'({j, k});
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= 1'b0;
      else q <= (w_cmd == JK_TOG) ? ~q : (w_cmd == JK_SET) ? 1'b1 : (w_cmd == JK_CLR) ? 1'b0 : q;
endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo up/down counter built from JK cells with load clamp, terminal count and registered wrap.
module jk_mod_counter
   import jk_mod_counter_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MOD   = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);
   localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);
   logic [WIDTH:0]   w_qx, w_dx;
   logic [WIDTH-1:0] w_inc, w_dec, w_ld, w_nxt, w_j, w_k;
   logic             w_at_last, w_at_zero, w_oor;
   logic             r_wrap;
   assign w_qx      = {1'b0, q};
   assign w_dx      = {1'b0, d};
   assign w_at_last = w_qx == {1'b0, LAST};
   assign w_at_zero = q == '0;
   assign w_oor     = w_qx > {1'b0, LAST};
   // an out-of-range count recovers to the wrap target of the requested direction
   assign w_inc     = (w_at_last | w_oor) ? '0 : WIDTH'(w_qx + 1'b1);
   assign w_dec     = (w_at_zero | w_oor) ? LAST : WIDTH'(w_qx - 1'b1);
   assign w_ld      = (w_dx > {1'b0, LAST}) ? LAST : d;
   assign w_nxt     = load ? w_ld : en ? (up ? w_inc : w_dec) : q;
   assign tc        = en & ~load & ((up & w_at_last) | (~up & w_at_zero));
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign {w_j[i], w_k[i]} = jk_min(q[i], w_nxt[i]);
      jk_cell u_cell (
         .clk  (clk),
         .rst_n(rst_n),
         .j    (w_j[i]),
         .k    (w_k[i]),
         .q    (q[i])
      );
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_wrap <= 1'b0;
      else r_wrap <= tc;
   assign wrap = r_wrap;
endmodule

// File: doc/jk_mod_counter.md
# jk_mod_counter

Parameterised synchronous modulo up/down counter whose state bits are held in JK flip-flop cells. Each cycle, excitation logic computes the desired next count and derives per-bit J/K inputs from it, which is the inverse of deriving D from J/K. The block is the team's standard JK-based counter primitive for dividers, BCD digits and sequencers. Its registered wrap pulse allows digits to be cascaded.

## Interface
Parameters:
- WIDTH, 4: count width in bits; must satisfy 2^WIDTH >= MOD.
- MOD, 10: modulus; count range is 0..MOD-1; MOD >= 2.

Ports:
- clk  input  1  Single clock; all state changes on its rising edge.
- rst_n  input  1  Reset, asynchronous and active-low; clears all state immediately on assertion.
- en  input  1  Count enable.
- up  input  1  Direction: 1 counts up, 0 counts down; sampled only when counting.
- load  input  1  Synchronous load strobe.
- d  input  WIDTH  Load value.
- q  output  WIDTH  Current count, driven directly from the JK cell outputs.
- tc  output  1  Terminal count, combinational.
- wrap  output  1  Registered one-cycle pulse the cycle after the count wraps.

## Operation
- Reset (rst_n=0): q=0 and wrap=0, asynchronously. tc follows its equation with q=0.
- Next-state value nxt, in priority order:
  - load=1: nxt = d if d <= MOD-1, else nxt = MOD-1 (clamp). en and up are ignored.
  - en=1, up=1: nxt = (q==MOD-1) ? 0 : q+1.
  - en=1, up=0: nxt = (q==0) ? MOD-1 : q-1.
  - otherwise: nxt = q (hold).
- Excitation per bit i, minimal form: j[i] = ~q[i] & nxt[i], k[i] = q[i] & ~nxt[i].
  - Unchanged bits receive j=k=0 (hold).
  - The J=K=1 toggle code is never generated.
- Each JK cell implements: 00 hold, 10 set, 01 clear, 11 toggle. The toggle code must still be implemented correctly in the cell, for cell-level tests.
- tc = en & ~load & ((up & q==MOD-1) | (~up & q==0)).
- wrap is registered: wrap <= tc, so it goes high for exactly one cycle after the wrapping edge.
- Arithmetic: computed at WIDTH+1 bits internally so that q+1 never overflows before the MOD compare. q must never exceed MOD-1 outside reset.
- If q is ever found out of range (for example, forced in simulation), the next enabled up-count goes to 0 and the next down-count goes to MOD-1. No X propagation.

## Timing
- Latency: load or count takes effect on q at the first rising clk edge where it is sampled (1 cycle).
- tc is valid in the same cycle as its inputs. wrap lags tc by exactly one cycle.
- Simultaneous load and en: load wins, and tc=0 that cycle.
- Direction change: takes effect immediately. Changing up at the terminal value changes tc in the same cycle.
- Reset asserted mid-count: q=0 within the reset assertion with no clock required, and any pending wrap is cleared. After deassertion, counting resumes at the first rising edge with rst_n=1.
- Back-to-back wraps (MOD=2, en=1 continuously): tc alternates each cycle, and wrap follows one cycle later.

## Structure
- The shared counter package holds:
  - a JK command encoding (HOLD=00, SET=10, CLR=01, TOG=11);
  - a helper that computes minimal J/K from (q, nxt).
- One sub-module, jk_cell: a single-bit JK flip-flop with clk, rst_n (async active-low, clears to 0), j, k and q. The top level instantiates WIDTH copies.
- The top level contains only the nxt mux, the clamp, the excitation helper, the tc logic and the wrap register.

## Test plan
- Reset: assert rst_n=0 mid-count at q=7, with no clock edge -> q=0 and wrap=0 immediately. Release rst_n; en=1, up=1 -> q=1 after the first edge.
- Up wrap (MOD=10): count from 0 with en=1, up=1 -> q steps through 0..9. At q=9, tc=1; the next edge gives q=0; wrap=1 for exactly the following cycle.
- Down wrap: load d=0, then en=1, up=0 -> tc=1 at q=0; the next edge gives q=9; wrap pulses once.
- Load priority and clamp:
  - load=1, en=1, d=5 -> q=5 and tc=0 that cycle.
  - d=13 -> q=9.
- Excitation check: at q=0111, count up -> bits 0-2 receive j=0,k=1, bit 3 receives j=1,k=0, and j=k=1 is never seen on any cell over a full up/down sweep.
- jk_cell standalone: from q=0, apply 10 -> q=1; 11 -> q=0; 11 -> q=1; 00 -> q=1; 01 -> q=0.
